// File: rtl/led_pkg.sv
// led_pkg: shared constants and types for the scanning-LED PWM output stage.
// Holds the default intensity width, the PWM period and the global brightness type.
// No ports; imported by led_trail_pwm and led_pwm_channel.
package led_pkg;

    localparam int LEVEL_BITS = 3;
    localparam int LEVEL_MAX  = (1 << LEVEL_BITS) - 1;

    // One PWM period per full intensity range, so duty granularity is 1/LEVEL_MAX.
    localparam int PWM_PERIOD = LEVEL_MAX;

    typedef logic [1:0] bright_t;

    localparam bright_t BRIGHT_RESET = 2'd3;

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED's trail intensity register, brightness scaling and PWM compare.
// Ports: clk, reset (sync, active-high), pos_bit (this LED's scanner bit), move (position changed),
//        g (global brightness), cnt (shared PWM counter), led (registered PWM drive).
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int LEVEL_BITS = led_pkg::LEVEL_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pos_bit,
    input  logic                  move,
    input  bright_t               g,
    input  logic [LEVEL_BITS-1:0] cnt,
    output logic                  led
);

    localparam logic [LEVEL_BITS-1:0] LVL_MAX = '1;
    // Intensity times (g+1) needs two extra bits (g+1 is at most 4).
    localparam int PW = LEVEL_BITS + 2;

    logic [LEVEL_BITS-1:0] level_q, level_d;
    logic                  led_q, led_d;
    logic [PW-1:0]         prod;
    logic [LEVEL_BITS-1:0] duty;

    always_comb begin
        level_d = level_q;
        if (pos_bit) begin
            // The active bit is pinned at full intensity, moving or held.
            level_d = LVL_MAX;
        end else if (move) begin
            // Trail decays only when the scanner moves, never with time.
            level_d = level_q >> 1;
        end

        prod  = PW'(level_q) * (PW'(g) + PW'(1));
        duty  = prod[PW-1:2];
        led_d = (duty > cnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: drives LED pins with PWM, each LED fading as a trail behind the scanner bit.
// Ports: clk, reset (sync, active-high), led_pos (one-hot scanner position), brightness_step
//        (single-cycle pulse), led_out (registered PWM drive), bright_level (global brightness g).
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LEVEL_BITS = led_pkg::LEVEL_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] led_pos,
    input  logic             brightness_step,
    output logic [WIDTH-1:0] led_out,
    output logic [1:0]       bright_level
);

    localparam logic [LEVEL_BITS-1:0] LVL_MAX  = '1;
    // Counter runs 0..LVL_MAX-1 so a full-intensity duty compares on every cycle.
    localparam logic [LEVEL_BITS-1:0] CNT_LAST = LVL_MAX - 1'b1;

    logic [WIDTH-1:0]      prev_pos_q, prev_pos_d;
    bright_t               g_q, g_d;
    logic [LEVEL_BITS-1:0] cnt_q, cnt_d;
    logic                  move;

    always_comb begin
        // Any difference counts as a move, including non-one-hot or all-zero input.
        move       = (led_pos != prev_pos_q);
        prev_pos_d = led_pos;

        g_d = g_q;
        if (brightness_step) begin
            g_d = bright_t'(g_q + 2'd1);
        end

        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pos_q <= '0;
            g_q        <= BRIGHT_RESET;
            cnt_q      <= '0;
        end else begin
            prev_pos_q <= prev_pos_d;
            g_q        <= g_d;
            cnt_q      <= cnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        led_pwm_channel #(
            .LEVEL_BITS (LEVEL_BITS)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .pos_bit (led_pos[i]),
            .move    (move),
            .g       (g_q),
            .cnt     (cnt_q),
            .led     (led_out[i])
        );
    end

    assign bright_level = g_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
module tb_led_trail_pwm;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] led_pos;
    logic       brightness_step;
    logic [7:0] led_out;
    logic [1:0] bright_level;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: intensities, brightness and PWM phase as plain integers.
    int         m_int [8];
    int         m_g;
    int         m_cnt;
    logic [7:0] m_prev;
    logic [7:0] m_led;

    typedef struct {
        logic       rst;
        logic [7:0] pos;
        logic       stp;
        logic [7:0] led;
        logic [1:0] br;
    } vec_t;

    vec_t tbl [14];

    led_trail_pwm #(.WIDTH(8), .LEVEL_BITS(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .led_pos         (led_pos),
        .brightness_step (brightness_step),
        .led_out         (led_out),
        .bright_level    (bright_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [7:0] p, input logic s);
        logic [7:0] nl;
        if (r) begin
            for (int i = 0; i < 8; i++) m_int[i] = 0;
            m_g = 3; m_cnt = 0; m_prev = 8'h00; m_led = 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) nl[i] = (((m_int[i] * (m_g + 1)) / 4) > m_cnt);
            for (int i = 0; i < 8; i++) begin
                if (p[i]) m_int[i] = 7;
                else if (p != m_prev) m_int[i] = m_int[i] / 2;
            end
            if (s) m_g = (m_g + 1) % 4;
            m_cnt  = (m_cnt + 1) % 7;
            m_prev = p;
            m_led  = nl;
        end
    endtask

    // Apply inputs for one edge, advance the model, compare just after the edge.
    task automatic tick(input logic r, input logic [7:0] p, input logic s);
        reset = r; led_pos = p; brightness_step = s;
        @(posedge clk);
        #1;
        model_edge(r, p, s);
        chk("model_led_out", int'(led_out), int'(m_led));
        chk("model_bright", int'(bright_level), m_g);
    endtask

    function automatic vec_t mk(logic r, logic [7:0] p, logic s, logic [7:0] l, logic [1:0] b);
        vec_t v;
        v.rst = r; v.pos = p; v.stp = s; v.led = l; v.br = b;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c [8];
        int hi;

        reset = 1'b1; led_pos = 8'h00; brightness_step = 1'b0;
        @(negedge clk);

        // Hand-derived cycle-by-cycle vectors: reset, hold, move with trail, brightness step.
        tbl[0]  = mk(1, 8'h00, 0, 8'h00, 2'd3);
        tbl[1]  = mk(0, 8'h01, 0, 8'h00, 2'd3);
        tbl[2]  = mk(0, 8'h01, 0, 8'h01, 2'd3);
        tbl[3]  = mk(0, 8'h01, 0, 8'h01, 2'd3);
        tbl[4]  = mk(0, 8'h01, 0, 8'h01, 2'd3);
        tbl[5]  = mk(0, 8'h02, 0, 8'h01, 2'd3);
        tbl[6]  = mk(0, 8'h02, 0, 8'h02, 2'd3);
        tbl[7]  = mk(0, 8'h02, 0, 8'h02, 2'd3);
        tbl[8]  = mk(0, 8'h02, 0, 8'h03, 2'd3);
        tbl[9]  = mk(0, 8'h02, 0, 8'h03, 2'd3);
        tbl[10] = mk(0, 8'h02, 0, 8'h03, 2'd3);
        tbl[11] = mk(0, 8'h02, 0, 8'h02, 2'd3);
        tbl[12] = mk(0, 8'h02, 1, 8'h02, 2'd0);
        tbl[13] = mk(0, 8'h02, 0, 8'h00, 2'd0);
        for (int k = 0; k < 14; k++) begin
            tick(tbl[k].rst, tbl[k].pos, tbl[k].stp);
            chk($sformatf("tbl%0d_led_out", k), int'(led_out), int'(tbl[k].led));
            chk($sformatf("tbl%0d_bright", k), int'(bright_level), int'(tbl[k].br));
        end

        // Hold 0x01 for 14 cycles: on continuously from the second cycle.
        tick(1, 8'h00, 0);
        chk("reset_led_out", int'(led_out), 0);
        chk("reset_bright", int'(bright_level), 3);
        tick(0, 8'h01, 0);
        for (int k = 1; k < 14; k++) begin
            tick(0, 8'h01, 0);
            chk("hold01_led_out", int'(led_out), 8'h01);
        end

        // Scan 01->02->04->08 then hold: duties 7,3,1,0 on LEDs 3..0.
        tick(1, 8'h00, 0);
        tick(0, 8'h01, 0); tick(0, 8'h02, 0); tick(0, 8'h04, 0); tick(0, 8'h08, 0);
        for (int i = 0; i < 8; i++) c[i] = 0;
        for (int k = 0; k < 7; k++) begin
            tick(0, 8'h08, 0);
            for (int i = 0; i < 8; i++) c[i] += int'(led_out[i]);
        end
        chk("trail_cnt3", c[3], 7);
        chk("trail_cnt2", c[2], 3);
        chk("trail_cnt1", c[1], 1);
        chk("trail_cnt0", c[0], 0);

        // Brightness step while holding 0x02: g=0 gives duty 1/7, four steps wrap to 3.
        tick(1, 8'h00, 0);
        tick(0, 8'h02, 0); tick(0, 8'h02, 0);
        tick(0, 8'h02, 1);
        chk("step_bright0", int'(bright_level), 0);
        hi = 0;
        for (int k = 0; k < 7; k++) begin
            tick(0, 8'h02, 0);
            hi += int'(led_out[1]);
        end
        chk("step_duty1", hi, 1);
        tick(0, 8'h02, 1); tick(0, 8'h02, 1); tick(0, 8'h02, 1);
        chk("step_wrap3", int'(bright_level), 3);

        // Step coincident with a move 02->04: I1=3 scaled to 0, I2=7 scaled to 1.
        tick(1, 8'h00, 0);
        tick(0, 8'h02, 0); tick(0, 8'h02, 0);
        tick(0, 8'h04, 1);
        chk("coinc_bright", int'(bright_level), 0);
        for (int i = 0; i < 8; i++) c[i] = 0;
        for (int k = 0; k < 7; k++) begin
            tick(0, 8'h04, 0);
            for (int i = 0; i < 8; i++) c[i] += int'(led_out[i]);
        end
        chk("coinc_cnt1", c[1], 0);
        chk("coinc_cnt2", c[2], 1);

        // Reset mid-trail, then release with 0x80.
        tick(1, 8'h00, 0);
        tick(0, 8'h01, 0); tick(0, 8'h02, 1); tick(0, 8'h04, 0); tick(0, 8'h04, 0);
        tick(1, 8'h80, 0);
        chk("midrst_led_out", int'(led_out), 0);
        chk("midrst_bright", int'(bright_level), 3);
        tick(0, 8'h80, 0);
        chk("midrst_rel1", int'(led_out), 0);
        tick(0, 8'h80, 0);
        chk("midrst_rel2", int'(led_out), 8'h80);

        // All-zero after 0x10: one decay to 3, then held (3 of every 7 cycles).
        tick(1, 8'h00, 0);
        tick(0, 8'h10, 0); tick(0, 8'h10, 0);
        tick(0, 8'h00, 0);
        hi = 0;
        for (int k = 0; k < 14; k++) begin
            tick(0, 8'h00, 0);
            hi += int'(led_out[4]);
        end
        chk("zero_hold_cnt4", hi, 6);

        // Randomized traffic against the reference model.
        tick(1, 8'h00, 0);
        for (int k = 0; k < 600; k++) begin
            logic [7:0] p;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)      p = m_prev;
            else if (sel < 8) p = 8'h01 << $urandom_range(0, 7);
            else              p = 8'($urandom);
            tick(($urandom_range(0, 79) == 0), p, ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_trail_pwm.md
# led_trail_pwm

Downstream output stage for the scanning-LED display. Consumes the one-hot LED position vector produced by the scanner and drives the physical LED pins with PWM. Each LED fades as a decaying trail behind the moving active bit, and a user button sets global brightness. Runs on the same ~6 kHz design clock as the scanner.

## Interface
- WIDTH, 8, number of LEDs; must be ≥ 2.
- LEVEL_BITS, 3, per-LED intensity width; LEVEL_MAX = 2^LEVEL_BITS−1 = 7.
- clk  input  1  design clock, rising-edge.
- reset  input  1  synchronous, active-high.
- led_pos  input  WIDTH  one-hot scanner position, clk-synchronous.
- brightness_step  input  1  single-cycle pulse, already synchronised and edge-detected upstream.
- led_out  output  WIDTH  PWM LED drive, registered.
- bright_level  output  2  current global brightness g.

## Operation
- Per-LED intensity register I[i], LEVEL_BITS wide; reset 0.
- Position tracking:
  - prev_pos register holds the last sampled led_pos; reset 0.
  - move = (led_pos != prev_pos), evaluated every cycle.
- Intensity update, per bit i, each cycle:
  - If led_pos[i]=1: I[i] ← LEVEL_MAX. This applies on a move and also while held.
  - Else if move: I[i] ← I[i] >> 1. A trail decays 7 → 3 → 1 → 0.
  - Else: I[i] holds.
- Non-one-hot input is tolerated and needs no check:
  - Every set bit is forced to LEVEL_MAX.
  - All-zero after a change decays every LED.
- Global brightness g, 2 bits; reset 3 (full).
  - brightness_step=1 sets g ← g+1, wrapping 3 → 0.
  - bright_level = g.
- Effective duty: E[i] = (I[i] × (g+1)) >> 2.
  - The product is computed at 5 bits, then truncated to LEVEL_BITS.
  - Range 0..7. Example: g=3, I=7 gives 7; g=0, I=7 gives 1.
- PWM counter cnt, LEVEL_BITS wide, free-running 0..LEVEL_MAX−1 (0..6), wraps to 0; reset 0.
- Output compare: led_out[i] ← (E[i] > cnt).
  - E=7: always on.
  - E=0: always off.
  - Otherwise on for exactly E of every 7 cycles.
- Simultaneous move and brightness_step: both apply in the same cycle. The new g affects E from the next cycle.
- Reset mid-operation: every register (I, prev_pos, g, cnt, led_out) returns to its reset value at the next edge, regardless of in-flight state.

## Timing
- Reset values: led_out = 0, bright_level = 3.
- Latency, led_pos change to led_out reflecting the new intensities: 2 cycles.
  - Edge 1 updates I.
  - Edge 2 registers led_out.
- brightness_step to bright_level: 1 cycle.
- brightness_step to a changed led_out duty: 2 cycles.
- PWM period: 7 cycles, about 857 Hz at 6 kHz.
- Duty granularity: 1/7.
- Trail decay occurs only on position moves. It never occurs on time, so trail length is independent of scan rate.

## Structure
- Shared package led_pkg:
  - LEVEL_BITS default and LEVEL_MAX.
  - PWM_PERIOD = LEVEL_MAX.
  - BRIGHT_RESET = 2'd3.
  - Typedef bright_t (2-bit).
- Sub-module led_pwm_channel, instantiated WIDTH times via generate:
  - Holds I[i], the E computation and the registered compare.
  - Inputs: clk, reset, pos_bit, move, g, cnt.
- The top level holds prev_pos, move detection, g and cnt.

## Test plan
- Reset, then hold led_pos=8'h01 for 14 cycles:
  - I[0]=7 after edge 1.
  - led_out=8'h01 continuously from cycle 2.
  - bright_level=3.
- Step led_pos 8'h01 → 8'h02 → 8'h04 → 8'h08, one cycle each, then hold:
  - I[3:0] = 7, 3, 1, 0.
  - Over 7 cycles, led_out[3] is high 7 times, [2] 3 times, [1] 1 time, [0] 0 times.
- Hold 8'h02 steady, pulse brightness_step once:
  - bright_level=0 next cycle.
  - led_out[1] is high 1 of 7 cycles (E=1).
  - Four pulses total return bright_level to 3.
- Pulse brightness_step in the same cycle as led_pos 8'h02 → 8'h04:
  - bright_level=0 and I[1]=3.
  - E[1] = (3×1)>>2 = 0, so led_out[1] stays low.
  - E[2]=1.
- Assert reset for 1 cycle mid-trail:
  - Next cycle led_out=0, bright_level=3, cnt=0, all I=0.
  - Releasing reset with led_pos=8'h80 gives led_out=8'h80 two cycles later.
- Drive led_pos=8'h00 after 8'h10 and hold:
  - I[4] decays once to 3 and then holds.
  - No further decay while input is unchanged.
